// File: rtl/bob_uart_tx_if.sv
// Byte-write handshake and serial-line status bundle for the bob_uart_tx transmitter.
interface bob_uart_tx_if;
  logic [7:0] data;
  logic       send;
  logic       ready;
  logic       overflow;
  logic       tx;
  logic       sending;

  modport master (
    output data, send,
    input  ready, overflow, tx, sending
  );

  modport slave (
    input  data, send,
    output ready, overflow, tx, sending
  );
endinterface

// File: rtl/bob_uart_tx.sv
// 8N1 UART transmitter fed by a small circular FIFO; one byte accepted per cycle while ready.
module bob_uart_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  bob_uart_tx_if.slave io_bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] FULL_CNT  = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_count;
  logic [15:0]   r_baud;
  logic [15:0]   w_baud_nxt;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_tx;
  logic          w_tx_nxt;
  logic          r_overflow;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_has;
  logic          w_baud_done;

  // ready looks only at the registered count, so a same-cycle pop never frees a slot early
  assign w_ready     = (r_count != FULL_CNT);
  assign w_push      = io_bus.send & w_ready;
  assign w_fifo_has  = (r_count != {PW{1'b0}});
  assign w_baud_done = (r_baud == BAUD_LAST);

  assign io_bus.ready    = w_ready;
  assign io_bus.overflow = r_overflow;
  assign io_bus.tx       = r_tx;
  assign io_bus.sending  = (r_state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {PW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= io_bus.data;
        r_wptr                <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + PW'(1);
        2'b01:   r_count <= r_count - PW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud + 16'd1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nxt = 16'd0;
        if (w_fifo_has) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr[AW-1:0]];
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (w_baud_done) begin
          w_baud_nxt    = 16'd0;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = DATA;
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (w_baud_done) begin
          w_baud_nxt    = 16'd0;
          w_shift_nxt   = {1'b0, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_state_nxt = DATA;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        if (w_baud_done) begin
          w_baud_nxt = 16'd0;
          if (w_fifo_has) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rptr[AW-1:0]];
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_baud_nxt  = 16'd0;
      end
    endcase

    // tx is registered from the next state so the start bit appears right after the pop edge
    case (w_state_nxt)
      IDLE:    w_tx_nxt = 1'b1;
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      STOP:    w_tx_nxt = 1'b1;
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_baud     <= 16'd0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_overflow <= io_bus.send & ~w_ready;
    end
  end
endmodule
